// File: rtl/sd_init_ctrl.sv
// SD card initialisation sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3, CMD7.
// Define SD_INIT_WIDE_BUS_EN to append CMD55/ACMD6 and select the 4-bit bus.
module sd_init_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int ACMD41_MAX     = 1023
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        istart,
    output logic        ocmd_start,
    output logic [5:0]  ocmd_index,
    output logic [31:0] ocmd_arg,
    output logic        ocmd_rst,
    input  logic [31:0] icmd_resp,
    input  logic        icmd_done,
    output logic [15:0] orca,
    output logic        owide,
    output logic        odone,
    output logic        oerror,
    output logic [2:0]  oerr_code
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [9:0]    ACMD_LIM  = 10'(ACMD41_MAX);

    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_ECHO    = 3'd2;
    localparam logic [2:0] ERR_ACMD41  = 3'd3;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, RST_DRV, EVAL, DONE, ERROR
    } state_e;

    typedef enum logic [3:0] {
        STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD2,
        STEP_CMD3, STEP_CMD7, STEP_CMD55_W, STEP_ACMD6
    } step_e;

    state_e         state_q, state_d;
    step_e          step_q, step_d;
    logic [RW-1:0]  retry_q, retry_d;
    logic [9:0]     acmd_cnt_q, acmd_cnt_d;
    logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
    logic           busy_seen_q, busy_seen_d;
    logic [31:0]    resp_q, resp_d;
    logic [5:0]     cmd_index_q, cmd_index_d;
    logic [31:0]    cmd_arg_q, cmd_arg_d;
    logic [15:0]    rca_q, rca_d;
    logic           wide_q, wide_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [2:0]     err_code_q, err_code_d;

    logic [5:0]     step_index;
    logic [31:0]    step_arg;
    logic           cmd_complete;
    logic [9:0]     acmd_next;
    logic           unused_resp_bits;

    // Response bits [15:8] carry nothing this sequencer acts on.
    assign unused_resp_bits = ^resp_q[15:8];

    always_comb begin
        step_index = 6'd0;
        step_arg   = 32'h0000_0000;
        unique case (step_q)
            STEP_CMD0:    begin step_index = 6'd0;  step_arg = 32'h0000_0000;    end
            STEP_CMD8:    begin step_index = 6'd8;  step_arg = 32'h0000_01AA;    end
            STEP_CMD55:   begin step_index = 6'd55; step_arg = 32'h0000_0000;    end
            STEP_ACMD41:  begin step_index = 6'd41; step_arg = 32'h40FF_8000;    end
            STEP_CMD2:    begin step_index = 6'd2;  step_arg = 32'h0000_0000;    end
            STEP_CMD3:    begin step_index = 6'd3;  step_arg = 32'h0000_0000;    end
            STEP_CMD7:    begin step_index = 6'd7;  step_arg = {rca_q, 16'h0000}; end
            STEP_CMD55_W: begin step_index = 6'd55; step_arg = {rca_q, 16'h0000}; end
            STEP_ACMD6:   begin step_index = 6'd6;  step_arg = 32'h0000_0002;    end
            default:      ;
        endcase
    end

    assign cmd_complete = busy_seen_q && icmd_done;
    assign acmd_next    = acmd_cnt_q + 10'd1;

    always_comb begin
        // NOTE: every next-state value defaults to its current register first, so no path infers a latch.
        state_d     = state_q;
        step_d      = step_q;
        retry_d     = retry_q;
        acmd_cnt_d  = acmd_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        busy_seen_d = busy_seen_q;
        resp_d      = resp_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        rca_d       = rca_q;
        wide_d      = wide_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (istart) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = 3'd0;
                    wide_d      = 1'b0;
                    rca_d       = 16'h0000;
                    retry_d     = '0;
                    acmd_cnt_d  = 10'd0;
                    wait_cnt_d  = '0;
                    busy_seen_d = 1'b0;
                    step_d      = STEP_CMD0;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                cmd_index_d = step_index;
                cmd_arg_d   = step_arg;
                wait_cnt_d  = '0;
                busy_seen_d = 1'b0;
                state_d     = WAIT;
            end

            WAIT: begin
                if (!icmd_done) begin
                    busy_seen_d = 1'b1;
                end
                // Completion outranks a timeout landing on the same cycle.
                if (cmd_complete) begin
                    resp_d  = icmd_resp;
                    state_d = EVAL;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = RST_DRV;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            RST_DRV: begin
                if (step_q == STEP_CMD0) begin
                    retry_d = '0;
                    step_d  = STEP_CMD8;
                    state_d = ISSUE;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ISSUE;
                end else begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ERROR;
                end
            end

            EVAL: begin
                retry_d = '0;
                state_d = ISSUE;
                unique case (step_q)
                    STEP_CMD0:  step_d = STEP_CMD8;
                    STEP_CMD8: begin
                        if (resp_q[7:0] == 8'hAA) begin
                            step_d = STEP_CMD55;
                        end else begin
                            error_d    = 1'b1;
                            err_code_d = ERR_ECHO;
                            state_d    = ERROR;
                        end
                    end
                    STEP_CMD55: step_d = STEP_ACMD41;
                    STEP_ACMD41: begin
                        if (resp_q[31]) begin
                            step_d = STEP_CMD2;
                        end else begin
                            acmd_cnt_d = acmd_next;
                            if (acmd_next == ACMD_LIM) begin
                                error_d    = 1'b1;
                                err_code_d = ERR_ACMD41;
                                state_d    = ERROR;
                            end else begin
                                step_d = STEP_CMD55;
                            end
                        end
                    end
                    STEP_CMD2:  step_d = STEP_CMD3;
                    STEP_CMD3: begin
                        rca_d  = resp_q[31:16];
                        step_d = STEP_CMD7;
                    end
`ifdef SD_INIT_WIDE_BUS_EN
                    STEP_CMD7:    step_d = STEP_CMD55_W;
                    STEP_CMD55_W: step_d = STEP_ACMD6;
                    STEP_ACMD6: begin
                        wide_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
`else
                    STEP_CMD7: begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
`endif
                    default: state_d = IDLE;
                endcase
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: irst is sampled on the clock edge only; the driver gets irst directly, so no ocmd_rst pulse here.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q     <= IDLE;
            step_q      <= STEP_CMD0;
            retry_q     <= '0;
            acmd_cnt_q  <= 10'd0;
            wait_cnt_q  <= '0;
            busy_seen_q <= 1'b0;
            resp_q      <= 32'h0000_0000;
            cmd_index_q <= 6'd0;
            cmd_arg_q   <= 32'h0000_0000;
            rca_q       <= 16'h0000;
            wide_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            retry_q     <= retry_d;
            acmd_cnt_q  <= acmd_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_seen_q <= busy_seen_d;
            resp_q      <= resp_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            rca_q       <= rca_d;
            wide_q      <= wide_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    // Index/arg are live during ISSUE, then held until the next ISSUE.
    assign ocmd_start = (state_q == ISSUE);
    assign ocmd_rst   = (state_q == RST_DRV);
    assign ocmd_index = (state_q == ISSUE) ? step_index : cmd_index_q;
    assign ocmd_arg   = (state_q == ISSUE) ? step_arg : cmd_arg_q;
    assign orca       = rca_q;
    assign owide      = wide_q;
    assign odone      = done_q;
    assign oerror     = error_q;
    assign oerr_code  = err_code_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Self-checking bench for sd_init_ctrl: behavioural card/driver model plus a protocol-level
// expectation of the command transcript, pulses and final status. Honours SD_INIT_WIDE_BUS_EN.
`timescale 1ns/1ps
module tb_sd_init_ctrl;

    localparam int TO = 64;
    localparam int MR = 3;
    localparam int AM = 5;

    logic        iclk = 1'b0;
    logic        irst;
    logic        istart;
    logic        ocmd_start;
    logic [5:0]  ocmd_index;
    logic [31:0] ocmd_arg;
    logic        ocmd_rst;
    logic [31:0] icmd_resp;
    logic        icmd_done;
    logic [15:0] orca;
    logic        owide;
    logic        odone;
    logic        oerror;
    logic [2:0]  oerr_code;

    sd_init_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY     (MR),
        .ACMD41_MAX    (AM)
    ) dut (
        .iclk      (iclk),
        .irst      (irst),
        .istart    (istart),
        .ocmd_start(ocmd_start),
        .ocmd_index(ocmd_index),
        .ocmd_arg  (ocmd_arg),
        .ocmd_rst  (ocmd_rst),
        .icmd_resp (icmd_resp),
        .icmd_done (icmd_done),
        .orca      (orca),
        .owide     (owide),
        .odone     (odone),
        .oerror    (oerror),
        .oerr_code (oerr_code)
    );

    always #5 iclk = ~iclk;

    int n_assert = 0;
    int n_fail   = 0;

    // Card behaviour for the current scenario
    int          busy_n;
    bit          cmd8_bad;
    int          dead_idx;
    logic [15:0] card_rca;

    // Observed transcript
    logic [5:0]  obs_idx[$];
    logic [31:0] obs_arg[$];
    int          rst_cnt;
    int          acmd_seen;

    // Expected results
    logic [5:0]  exp_idx[$];
    logic [31:0] exp_arg[$];
    int          exp_rst;
    logic        exp_done;
    logic        exp_err;
    logic        exp_wide;
    logic [2:0]  exp_code;
    logic [15:0] exp_rca;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Card + CMD-line driver: CMD0 and the scenario's dead command are never answered.
    initial begin : card
        logic [5:0]  idx;
        logic [31:0] resp;
        logic [31:0] r;
        bit          ready;
        icmd_done = 1'b1;
        icmd_resp = 32'h0;
        forever begin
            @(negedge iclk);
            if (ocmd_rst) rst_cnt++;
            if (ocmd_start) begin
                idx = ocmd_index;
                obs_idx.push_back(idx);
                obs_arg.push_back(ocmd_arg);
                r = $urandom;
                if (idx != 6'd0 && int'(idx) != dead_idx) begin
                    case (idx)
                        6'd8:    resp = cmd8_bad ? 32'h0000_01AB : {r[31:8], 8'hAA};
                        6'd41: begin
                            ready = (acmd_seen >= busy_n);
                            resp  = {ready, r[30:0]};
                            acmd_seen++;
                        end
                        6'd3:    resp = {card_rca, r[15:0]};
                        default: resp = r;
                    endcase
                    repeat ($urandom_range(0, 3)) @(negedge iclk);
                    icmd_done = 1'b0;
                    repeat ($urandom_range(2, 6)) @(negedge iclk);
                    check("cmd_index_stable", {26'd0, ocmd_index}, {26'd0, idx});
                    icmd_resp = resp;
                    icmd_done = 1'b1;
                end
            end
        end
    end

    task automatic model_issue(input logic [5:0] idx, input logic [31:0] arg, output bit ok);
        int copies;
        copies = (int'(idx) == dead_idx) ? MR + 1 : 1;
        for (int i = 0; i < copies; i++) begin
            exp_idx.push_back(idx);
            exp_arg.push_back(arg);
        end
        ok = (copies == 1);
        if (!ok) begin
            exp_rst += copies;
            exp_code = 3'd1;
        end
    endtask

    // Walks the init protocol at command level to predict transcript and final status.
    task automatic build_model();
        bit alive;
        exp_idx.delete();
        exp_arg.delete();
        exp_code = 3'd0;
        exp_rca  = 16'h0;
        exp_wide = 1'b0;
        exp_idx.push_back(6'd0);
        exp_arg.push_back(32'h0);
        exp_rst = 1;
        model_issue(6'd8, 32'h0000_01AA, alive);
        if (alive && cmd8_bad) begin
            exp_code = 3'd2;
            alive    = 1'b0;
        end
        for (int k = 0; alive; k++) begin
            model_issue(6'd55, 32'h0, alive);
            if (alive) model_issue(6'd41, 32'h40FF_8000, alive);
            if (!alive || k >= busy_n) break;
            if (k + 1 >= AM) begin
                exp_code = 3'd3;
                alive    = 1'b0;
            end
        end
        if (alive) model_issue(6'd2, 32'h0, alive);
        if (alive) model_issue(6'd3, 32'h0, alive);
        if (alive) exp_rca = card_rca;
        if (alive) model_issue(6'd7, {card_rca, 16'h0}, alive);
`ifdef SD_INIT_WIDE_BUS_EN
        if (alive) model_issue(6'd55, {card_rca, 16'h0}, alive);
        if (alive) model_issue(6'd6, 32'h0000_0002, alive);
        if (alive) exp_wide = 1'b1;
`endif
        exp_done = alive;
        exp_err  = (exp_code != 3'd0);
    endtask

    function automatic int count_idx(input logic [5:0] idx);
        int n = 0;
        foreach (obs_idx[i]) if (obs_idx[i] == idx) n++;
        return n;
    endfunction

    task automatic pulse_start();
        @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        istart = 1'b0;
    endtask

    task automatic set_card(input int b, input bit bad8, input int dead, input logic [15:0] rca);
        busy_n    = b;
        cmd8_bad  = bad8;
        dead_idx  = dead;
        card_rca  = rca;
        obs_idx.delete();
        obs_arg.delete();
        rst_cnt   = 0;
        acmd_seen = 0;
    endtask

    task automatic run_scenario(input string name, input int b, input bit bad8, input int dead,
                                input logic [15:0] rca, input bit poke);
        int cyc;
        set_card(b, bad8, dead, rca);
        build_model();
        pulse_start();
        if (poke) begin
            // A second istart mid-sequence must be ignored.
            cyc = 0;
            while (obs_idx.size() < 2 && cyc < 1000) begin
                @(negedge iclk);
                cyc++;
            end
            pulse_start();
        end
        cyc = 0;
        while (!(odone || oerror) && cyc < 20000) begin
            @(negedge iclk);
            cyc++;
        end
        check({name, ":finished"}, {31'd0, odone || oerror}, 32'd1);
        repeat (20) @(negedge iclk);
        check({name, ":n_cmds"}, obs_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < obs_idx.size(); i++) begin
            check($sformatf("%s:idx[%0d]", name, i), {26'd0, obs_idx[i]}, {26'd0, exp_idx[i]});
            check($sformatf("%s:arg[%0d]", name, i), obs_arg[i], exp_arg[i]);
        end
        check({name, ":n_rst"},    rst_cnt, exp_rst);
        check({name, ":odone"},    {31'd0, odone}, {31'd0, exp_done});
        check({name, ":oerror"},   {31'd0, oerror}, {31'd0, exp_err});
        check({name, ":err_code"}, {29'd0, oerr_code}, {29'd0, exp_code});
        check({name, ":orca"},     {16'd0, orca}, {16'd0, exp_rca});
        check({name, ":owide"},    {31'd0, owide}, {31'd0, exp_wide});
    endtask

    task automatic check_all_zero(input string name);
        check({name, ":ocmd_start"}, {31'd0, ocmd_start}, 32'd0);
        check({name, ":ocmd_rst"},   {31'd0, ocmd_rst}, 32'd0);
        check({name, ":ocmd_index"}, {26'd0, ocmd_index}, 32'd0);
        check({name, ":ocmd_arg"},   ocmd_arg, 32'd0);
        check({name, ":orca"},       {16'd0, orca}, 32'd0);
        check({name, ":owide"},      {31'd0, owide}, 32'd0);
        check({name, ":odone"},      {31'd0, odone}, 32'd0);
        check({name, ":oerror"},     {31'd0, oerror}, 32'd0);
        check({name, ":oerr_code"},  {29'd0, oerr_code}, 32'd0);
    endtask

    initial begin : watchdog
        repeat (90000) @(posedge iclk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int cyc;
        int n_before;
        bit found;
        int dead_opts[6];
        dead_opts = '{-1, 8, 55, 41, 3, 7};

        irst     = 1'b1;
        istart   = 1'b0;
        busy_n   = 0;
        cmd8_bad = 1'b0;
        dead_idx = -1;
        card_rca = 16'h0;
        rst_cnt  = 0;
        acmd_seen = 0;
        repeat (3) @(negedge iclk);
        irst = 1'b0;
        check_all_zero("reset");

        // Nominal card, two busy ACMD41 replies, istart poked mid-run
        run_scenario("nominal", 2, 1'b0, -1, 16'h1234, 1'b1);
        check("nominal:cmd41_issues", count_idx(6'd41), 32'd3);
        check("nominal:one_rst", rst_cnt, 32'd1);
        check("nominal:orca_lit", {16'd0, orca}, 32'h1234);

        // Bad CMD8 echo
        run_scenario("cmd8_echo", 0, 1'b1, -1, 16'h1234, 1'b0);
        check("cmd8_echo:code_lit", {29'd0, oerr_code}, 32'd2);

        // CMD2 never answered
        run_scenario("cmd2_dead", 0, 1'b0, 2, 16'h1234, 1'b0);
        check("cmd2_dead:cmd2_issues", count_idx(6'd2), 32'd4);
        check("cmd2_dead:rst_after_cmd0", rst_cnt - 1, 32'd4);
        check("cmd2_dead:code_lit", {29'd0, oerr_code}, 32'd1);

        // Card stays busy forever
        run_scenario("acmd41_limit", 1000, 1'b0, -1, 16'h1234, 1'b0);
        check("acmd41_limit:cmd41_issues", count_idx(6'd41), 32'd5);
        check("acmd41_limit:code_lit", {29'd0, oerr_code}, 32'd3);

        // irst while waiting on ACMD41
        set_card(0, 1'b0, 41, 16'h5555);
        pulse_start();
        cyc   = 0;
        found = 1'b0;
        while (!found && cyc < 2000) begin
            @(negedge iclk);
            cyc++;
            found = (obs_idx.size() > 0) && (obs_idx[obs_idx.size() - 1] == 6'd41);
        end
        check("reset_mid:reached_cmd41", {31'd0, found}, 32'd1);
        repeat (3) @(negedge iclk);
        irst = 1'b1;
        @(negedge iclk);
        irst = 1'b0;
        check_all_zero("reset_mid");
        check("reset_mid:rst_pulses", rst_cnt, 32'd1);
        n_before = obs_idx.size();
        repeat (2 * TO) @(negedge iclk);
        check("reset_mid:stays_idle", obs_idx.size(), n_before);
        check("reset_mid:no_rst_pulse", rst_cnt, 32'd1);
        run_scenario("after_reset", 1, 1'b0, -1, 16'h0F0F, 1'b0);

        // RCA used by CMD7 (and the wide-bus CMD55 when enabled)
        run_scenario("rca_beef", 0, 1'b0, -1, 16'hBEEF, 1'b0);

        for (int n = 0; n < 6; n++) begin
            run_scenario($sformatf("rand%0d", n), $urandom_range(0, 6),
                         ($urandom_range(0, 4) == 0), dead_opts[$urandom_range(0, 5)],
                         16'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
